// File: rtl/cursor_input.sv
// ---------------------------------------------------------------------------
// cursor_input
//   Turns three raw active-low pushbuttons into cursor moves and grid writes.
//   Each button is synchronized (two flops), debounced, and edge-detected
//   into a single-cycle press event. Down/right presses step the cursor over
//   a 9x9 grid with wrap-around. A place press captures the cursor position
//   and the num_select value into a write request that is held until the
//   grid accepts it with cell_wr_ready.
//
// Ports
//   clk            in   system clock, rising edge
//   reset_n        in   synchronous active-low reset
//   cursor_down    in   raw button, active-low, asynchronous
//   cursor_right   in   raw button, active-low, asynchronous
//   place_btn      in   raw button, active-low, asynchronous
//   num_select     in   [3:0] value to write; 0 clears, 1-9 digit, >9 invalid
//   cursor_row     out  [3:0] cursor row, 0-8
//   cursor_col     out  [3:0] cursor column, 0-8
//   cell_wr        out  write request valid
//   cell_wr_row    out  [3:0] row of pending write
//   cell_wr_col    out  [3:0] column of pending write
//   cell_wr_data   out  [3:0] value of pending write
//   cell_wr_ready  in   grid accepts write when cell_wr & cell_wr_ready
// ---------------------------------------------------------------------------
module cursor_input #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cursor_down,
  input  logic       cursor_right,
  input  logic       place_btn,
  input  logic [3:0] num_select,
  output logic [3:0] cursor_row,
  output logic [3:0] cursor_col,
  output logic       cell_wr,
  output logic [3:0] cell_wr_row,
  output logic [3:0] cell_wr_col,
  output logic [3:0] cell_wr_data,
  input  logic       cell_wr_ready
);

  // Counter must be able to hold the value DEBOUNCE_CYCLES itself.
  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Button index within the 3-bit vectors.
  localparam int B_DOWN  = 0;
  localparam int B_RIGHT = 1;
  localparam int B_PLACE = 2;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } wr_state_t;

  logic [2:0]    w_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_db_level;
  logic [CW-1:0] r_db_cnt [0:2];
  logic [2:0]    w_press;

  logic [3:0]    r_row;
  logic [3:0]    r_col;

  wr_state_t     r_state;
  wr_state_t     w_state_next;
  logic          w_capture;
  logic          r_cell_wr;
  logic [3:0]    r_wr_row;
  logic [3:0]    r_wr_col;
  logic [3:0]    r_wr_data;

  assign w_raw = {place_btn, cursor_right, cursor_down};

  // Two-flop synchronizer; released level (1) out of reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncers: count cycles of disagreement, adopt new level at the limit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_db_level <= 3'b111;
      for (int i = 0; i < 3; i++) begin
        r_db_cnt[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_db_level[i]) begin
          r_db_cnt[i] <= CNT_ZERO;
        end else if (r_db_cnt[i] == CNT_MAX) begin
          r_db_level[i] <= r_sync2[i];
          r_db_cnt[i]   <= CNT_ZERO;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Press pulse: high exactly in the cycle the debounced level falls 1->0,
  // so a held button yields one event and a release yields none.
  always_comb begin
    w_press = 3'b000;
    for (int i = 0; i < 3; i++) begin
      w_press[i] = r_db_level[i] & ~r_sync2[i] & (r_db_cnt[i] == CNT_MAX);
    end
  end

  // Cursor position; down and right are independent and may both apply.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_row <= 4'd4;
      r_col <= 4'd4;
    end else begin
      if (w_press[B_DOWN]) begin
        r_row <= (r_row >= 4'd8) ? 4'd0 : r_row + 4'd1;
      end else begin
        r_row <= r_row;
      end
      if (w_press[B_RIGHT]) begin
        r_col <= (r_col >= 4'd8) ? 4'd0 : r_col + 4'd1;
      end else begin
        r_col <= r_col;
      end
    end
  end

  // Write FSM next-state: accept a valid place press only when idle.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_press[B_PLACE] && (num_select <= 4'd9)) begin
          w_state_next = ST_PENDING;
          w_capture    = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (cell_wr_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_PENDING;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Write FSM state, request flag and captured fields. Capture uses the
  // pre-move cursor because r_row/r_col update on the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cell_wr <= 1'b0;
      r_wr_row  <= 4'd0;
      r_wr_col  <= 4'd0;
      r_wr_data <= 4'd0;
    end else begin
      r_state   <= w_state_next;
      r_cell_wr <= (w_state_next == ST_PENDING);
      if (w_capture) begin
        r_wr_row  <= r_row;
        r_wr_col  <= r_col;
        r_wr_data <= num_select;
      end else begin
        r_wr_row  <= r_wr_row;
        r_wr_col  <= r_wr_col;
        r_wr_data <= r_wr_data;
      end
    end
  end

  assign cursor_row   = r_row;
  assign cursor_col   = r_col;
  assign cell_wr      = r_cell_wr;
  assign cell_wr_row  = r_wr_row;
  assign cell_wr_col  = r_wr_col;
  assign cell_wr_data = r_wr_data;

endmodule
